// File: rtl/i2c_slave_regfile.sv
`timescale 1ns/1ps
// i2c_slave_regfile: AT24C02-style 256x8 I2C responder running on clk_12m.
// SCL/SDA are oversampled; SDA is driven open-drain and SCL is never stretched.
module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR  = 7'h50,
    parameter logic [7:0] MEM_RESET = 8'hFF
) (
    input  logic       clk_12m,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       wr_pulse,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [7:0] state_debug
);

    typedef enum logic [3:0] {
        IDLE   = 4'h0,
        DEVADR = 4'h1,
        DEVACK = 4'h2,
        REGADR = 4'h3,
        REGACK = 4'h4,
        WRDATA = 4'h5,
        WRACK  = 4'h6,
        RDDATA = 4'h7,
        RDACK  = 4'h8
    } state_t;

    state_t     state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic [6:0] shreg, shreg_nx;
    logic       sda_oe, oe_nx;
    logic [7:0] ptr, ptr_nx;
    logic       rw, rw_nx;
    logic       busy_nx;
    logic       mem_we;
    logic [7:0] rx_byte;
    logic [7:0] rd_byte;
    logic [7:0] mem [256];

    // [0] first sync flop, [1] synced value, [2] history for edge detection
    logic [2:0] scl_sr, sda_sr;
    logic       scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            scl_sr <= 3'b111;
            sda_sr <= 3'b111;
        end else begin
            scl_sr <= {scl_sr[1:0], scl};
            sda_sr <= {sda_sr[1:0], sda};
        end
    end

    assign scl_rise  = scl_sr[1] & ~scl_sr[2];
    assign scl_fall  = ~scl_sr[1] & scl_sr[2];
    assign start_det = scl_sr[1] & scl_sr[2] & sda_sr[2] & ~sda_sr[1];
    assign stop_det  = scl_sr[1] & scl_sr[2] & ~sda_sr[2] & sda_sr[1];

    assign rx_byte     = {shreg, sda_sr[1]};
    assign rd_byte     = mem[ptr];
    assign dbg_data    = mem[dbg_addr];
    assign state_debug = {4'h0, state};
    assign sda         = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            shreg    <= 7'd0;
            sda_oe   <= 1'b0;
            ptr      <= 8'd0;
            rw       <= 1'b0;
            busy     <= 1'b0;
            wr_pulse <= 1'b0;
            wr_addr  <= 8'd0;
            wr_data  <= 8'd0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            shreg    <= shreg_nx;
            sda_oe   <= oe_nx;
            ptr      <= ptr_nx;
            rw       <= rw_nx;
            busy     <= busy_nx;
            wr_pulse <= mem_we;
            if (mem_we) begin
                wr_addr <= ptr;
                wr_data <= rx_byte;
            end
        end
    end

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= MEM_RESET;
        end else if (mem_we) begin
            mem[ptr] <= rx_byte;
        end
    end

    // Bit counter wraps 7->0 on the 8th bit, so each byte phase starts cleared.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shreg_nx = shreg;
        oe_nx    = sda_oe;
        ptr_nx   = ptr;
        rw_nx    = rw;
        busy_nx  = busy;
        mem_we   = 1'b0;
        if (start_det) begin
            state_nx = DEVADR;
            cnt_nx   = 3'd0;
            busy_nx  = 1'b1;
        end else if (stop_det) begin
            state_nx = IDLE;
            cnt_nx   = 3'd0;
            busy_nx  = 1'b0;
            oe_nx    = 1'b0;
        end else begin
            unique case (state)
                DEVADR: if (scl_rise) begin
                    shreg_nx = rx_byte[6:0];
                    cnt_nx   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        rw_nx    = rx_byte[0];
                        state_nx = (rx_byte[7:1] == DEV_ADDR) ? DEVACK : IDLE;
                    end
                end
                REGADR: if (scl_rise) begin
                    shreg_nx = rx_byte[6:0];
                    cnt_nx   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        ptr_nx   = rx_byte;
                        state_nx = REGACK;
                    end
                end
                WRDATA: if (scl_rise) begin
                    shreg_nx = rx_byte[6:0];
                    cnt_nx   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        mem_we   = 1'b1;
                        ptr_nx   = ptr + 8'd1;
                        state_nx = WRACK;
                    end
                end
                // First falling edge asserts the ACK, the second ends it.
                DEVACK, REGACK, WRACK: if (scl_fall) begin
                    if (cnt == 3'd0) begin
                        oe_nx  = 1'b1;
                        cnt_nx = 3'd1;
                    end else begin
                        cnt_nx = 3'd0;
                        if (state == DEVACK && rw) begin
                            state_nx = RDDATA;
                            shreg_nx = rd_byte[6:0];
                            oe_nx    = ~rd_byte[7];
                        end else begin
                            oe_nx    = 1'b0;
                            state_nx = (state == DEVACK) ? REGADR : WRDATA;
                        end
                    end
                end
                RDDATA: if (scl_fall) begin
                    if (cnt == 3'd7) begin
                        oe_nx    = 1'b0;
                        cnt_nx   = 3'd0;
                        state_nx = RDACK;
                    end else begin
                        oe_nx    = ~shreg[6];
                        shreg_nx = {shreg[5:0], 1'b0};
                        cnt_nx   = cnt + 3'd1;
                    end
                end
                RDACK: begin
                    if (scl_rise) begin
                        ptr_nx = ptr + 8'd1;
                        if (sda_sr[1]) state_nx = IDLE;
                        else           cnt_nx   = 3'd1;
                    end else if (scl_fall && cnt == 3'd1) begin
                        cnt_nx   = 3'd0;
                        state_nx = RDDATA;
                        shreg_nx = rd_byte[6:0];
                        oe_nx    = ~rd_byte[7];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
